// File: rtl/fastinput_sched.sv
// Gate-window snapshot of four edge counters, deltas streamed one channel per beat; first beat 1 cycle after snap.
// Beats hold under out_ready=0, window timing unaffected (snap while busy -> sticky overrun); FASTIN_SCHED_SKIP_ZERO_EN skips zero deltas.
module fastinput_sched #(
    parameter int GATE_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [31:0] i_channel0,
    input  logic [31:0] i_channel1,
    input  logic [31:0] i_channel2,
    input  logic [31:0] i_channel3,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_data,
    output logic [1:0]  o_out_ch,
    output logic        o_out_last,
    output logic        o_snap,
    output logic        o_busy,
    output logic        o_overrun,
    input  logic        i_ovf_clr
);
    localparam int WW = $clog2(GATE_CYCLES);
    localparam logic [WW-1:0] W_LAST = WW'(GATE_CYCLES - 1);
    localparam logic [WW-1:0] W_PRE  = WW'(GATE_CYCLES - 2);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t        r_state, w_state_nxt;
    logic [WW-1:0] r_wcnt;
    logic          r_en_d, r_snap, r_overrun;
    logic [1:0]    r_ch, w_ch_nxt, w_ch_adv;
    logic [31:0]   r_prev  [4];
    logic [31:0]   r_delta [4];
    logic [31:0]   w_chan  [4];
    logic [31:0]   w_diff  [4];
    logic          w_hs, w_last, w_capture, w_ovr_set, w_arm;

    assign w_chan[0] = i_channel0;
    assign w_chan[1] = i_channel1;
    assign w_chan[2] = i_channel2;
    assign w_chan[3] = i_channel3;
    assign w_arm     = i_en & ~r_en_d;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_diff[i] = w_chan[i] - r_prev[i];
        end
    end

`ifdef FASTIN_SCHED_SKIP_ZERO_EN
    logic [1:0] w_first;
    logic       w_any;

    // Descending scans leave the lowest qualifying index selected.
    always_comb begin
        w_ch_adv = r_ch;
        w_last   = 1'b1;
        w_first  = 2'd0;
        w_any    = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(r_ch) && r_delta[i] != 32'd0) begin
                w_ch_adv = 2'(i);
                w_last   = 1'b0;
            end
            if (w_diff[i] != 32'd0) begin
                w_first = 2'(i);
                w_any   = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_ch_adv = r_ch + 2'd1;
        w_last   = (r_ch == 2'd3);
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_capture   = 1'b0;
        w_ovr_set   = 1'b0;
        w_hs        = (r_state == S_SEND) && i_out_ready;
        // A snap landing on the final handshake starts the next readout back-to-back.
        if (r_snap && (r_state == S_IDLE || (w_hs && w_last))) begin
            w_capture = 1'b1;
`ifdef FASTIN_SCHED_SKIP_ZERO_EN
            w_state_nxt = w_any ? S_SEND : S_IDLE;
            w_ch_nxt    = w_first;
`else
            w_state_nxt = S_SEND;
            w_ch_nxt    = 2'd0;
`endif
        end else begin
            w_ovr_set = r_snap;
            if (w_hs) begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ch_nxt = w_ch_adv;
                end
            end
        end
    end

    assign o_out_valid = (r_state == S_SEND);
    assign o_busy      = (r_state == S_SEND);
    assign o_out_data  = o_out_valid ? r_delta[r_ch] : 32'd0;
    assign o_out_ch    = o_out_valid ? r_ch : 2'd0;
    assign o_out_last  = o_out_valid & w_last;
    assign o_snap      = r_snap;
    assign o_overrun   = r_overrun;

    // r_en_d resets high so a window already enabled at reset reports raw counts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ch      <= 2'd0;
            r_wcnt    <= '0;
            r_en_d    <= 1'b1;
            r_snap    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_prev[i]  <= 32'd0;
                r_delta[i] <= 32'd0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_en_d  <= i_en;
            r_snap  <= i_en && (r_wcnt == W_PRE);
            if (!i_en || r_wcnt == W_LAST) begin
                r_wcnt <= '0;
            end else begin
                r_wcnt <= r_wcnt + WW'(1);
            end
            for (int i = 0; i < 4; i++) begin
                if (w_capture) begin
                    r_delta[i] <= w_diff[i];
                    r_prev[i]  <= w_chan[i];
                end else if (w_arm) begin
                    r_prev[i] <= w_chan[i];
                end
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fastinput_sched.sv
// Scoreboard bench for fastinput_sched: a window/readout model pushes expected beats, a negedge monitor pops them.
module tb_fastinput_sched;
    localparam int G = 10;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  c;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, en, out_ready, ovf_clr;
    logic [31:0] chv [4];
    logic        o_valid, o_last, o_snap, o_busy, o_ovr;
    logic [31:0] o_data;
    logic [1:0]  o_ch;

    int          n_chk = 0;
    int          n_err = 0;
    beat_t       q[$];
    int          m_out = 0;
    int          m_cnt = 0;
    bit          m_en_prev = 1'b1;
    bit          m_ovr = 1'b0;
    bit          m_snap_exp = 1'b0;
    bit          m_capt = 1'b0;
    logic [31:0] m_prev [4];
    logic [31:0] mon_d  [4];
    int          inc [4];
    bit          rnd_inc = 1'b0;

    always #5 clk = ~clk;

    fastinput_sched #(.GATE_CYCLES(G)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_channel0  (chv[0]),
        .i_channel1  (chv[1]),
        .i_channel2  (chv[2]),
        .i_channel3  (chv[3]),
        .o_out_valid (o_valid),
        .i_out_ready (out_ready),
        .o_out_data  (o_data),
        .o_out_ch    (o_ch),
        .o_out_last  (o_last),
        .o_snap      (o_snap),
        .o_busy      (o_busy),
        .o_overrun   (o_ovr),
        .i_ovf_clr   (ovf_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of one rising edge, using the inputs the DUT just sampled.
    task automatic model_edge();
        bit          hs, capt, set;
        logic [31:0] d [4];
        int          hi;
        beat_t       b;
        m_capt = 1'b0;
        if (rst) begin
            q.delete();
            m_out = 0;
            m_cnt = 0;
            m_en_prev = 1'b1;
            m_ovr = 1'b0;
            m_snap_exp = 1'b0;
            for (int i = 0; i < 4; i++) m_prev[i] = 32'd0;
            return;
        end
        set  = 1'b0;
        hs   = (m_out > 0) && out_ready;
        capt = (m_cnt % G) == G - 1;
        if (hs) m_out--;
        if (capt) begin
            m_capt = 1'b1;
            if (m_out == 0) begin
                for (int i = 0; i < 4; i++) begin
                    d[i] = chv[i] - m_prev[i];
                    m_prev[i] = chv[i];
                end
`ifdef FASTIN_SCHED_SKIP_ZERO_EN
                hi = -1;
                for (int i = 0; i < 4; i++) if (d[i] != 0) hi = i;
                for (int i = 0; i < 4; i++) begin
                    if (d[i] != 0) begin
                        b.d = d[i]; b.c = 2'(i); b.l = (i == hi);
                        q.push_back(b);
                        m_out++;
                    end
                end
`else
                hi = 3;
                for (int i = 0; i < 4; i++) begin
                    b.d = d[i]; b.c = 2'(i); b.l = (i == hi);
                    q.push_back(b);
                    m_out++;
                end
`endif
            end else begin
                set = 1'b1;
            end
        end
        if (set) m_ovr = 1'b1;
        else if (ovf_clr) m_ovr = 1'b0;
        if (en && !m_en_prev) begin
            for (int i = 0; i < 4; i++) m_prev[i] = chv[i];
        end
        m_en_prev = en;
        m_cnt = en ? m_cnt + 1 : 0;
        m_snap_exp = (m_cnt % G) == G - 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        if (rnd_inc) begin
            chv[0] += 32'($urandom_range(0, 3));
            chv[1] += 32'($urandom_range(0, 1));
            chv[2] += ($urandom_range(0, 9) == 0) ? 32'd1 : 32'd0;
            chv[3] += ($urandom_range(0, 15) == 0) ? 32'd1 : 32'd0;
        end else begin
            for (int i = 0; i < 4; i++) chv[i] += 32'(inc[i]);
        end
    endtask

    // Advance to the next window-close edge, bounded.
    task automatic ruc();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!m_capt && k < 3 * G);
        if (!m_capt) begin
            n_chk++;
            n_err++;
            $display("FAIL window_timeout: no window close within %0d cycles", 3 * G);
        end
    endtask

    always @(negedge clk) begin
        chk("valid", 32'(o_valid), 32'(m_out > 0));
        chk("busy", 32'(o_busy), 32'(m_out > 0));
        chk("snap", 32'(o_snap), 32'(m_snap_exp));
        chk("overrun", 32'(o_ovr), 32'(m_ovr));
        if (!o_valid) begin
            chk("idle_data", o_data, 32'd0);
            chk("idle_ch", 32'(o_ch), 32'd0);
            chk("idle_last", 32'(o_last), 32'd0);
        end else if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_beat: ch %0d data %0h, none expected", o_ch, o_data);
        end else begin
            chk("beat_data", o_data, q[0].d);
            chk("beat_ch", 32'(o_ch), 32'(q[0].c));
            chk("beat_last", 32'(o_last), 32'(q[0].l));
            if (out_ready && !rst) begin
                mon_d[o_ch] = o_data;
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] raw;
        rst = 1'b1; en = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chv[i] = 32'd0; inc[i] = 0; mon_d[i] = 32'd0; m_prev[i] = 32'd0;
        end
        tick();
        tick();
        rst = 1'b0;

        // channel0 one edge every 5 cycles
        for (int k = 0; k < 6 * G; k++) begin
            if (k % 5 == 0) chv[0]++;
            tick();
        end
        chk("ch0_per_window", mon_d[0], 32'd2);

        chv[0] = 32'hFFFF_FFFE;
        ruc();
        chv[0] = 32'h0000_0001;
        ruc();
        repeat (6) tick();
        chk("wrap_delta", mon_d[0], 32'd3);

        // stall across a window close, then release
        inc[0] = 1;
        ruc();
        out_ready = 1'b0;
        repeat (15) tick();
        chk("overrun_set", 32'(o_ovr), 32'd1);
        out_ready = 1'b1;
        ruc();
        repeat (6) tick();
        chk("two_window_delta", mon_d[0], 32'(2 * G));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("overrun_clr", 32'(o_ovr), 32'd0);

        // final handshake lands on the window-close edge
        for (int i = 0; i < 4; i++) inc[i] = 1;
        for (int k = 0; k < 4 * G; k++) begin
            out_ready = (m_cnt % G) >= 6;
            tick();
        end
        out_ready = 1'b1;
        chk("coincident_no_overrun", 32'(o_ovr), 32'd0);

        // reset during the ch1 beat with overrun pending
        out_ready = 1'b0;
        ruc();
        ruc();
        out_ready = 1'b1;
        ruc();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_overrun", 32'(o_ovr), 32'd0);
        ruc();
        raw = m_prev[1];
        repeat (6) tick();
        chk("raw_after_rst", mon_d[1], raw);

        // enable re-arm with a static offset on channel2
        for (int i = 0; i < 4; i++) inc[i] = 0;
        en = 1'b0;
        repeat (3) tick();
        chv[2] = 32'd1000;
        tick();
        en = 1'b1;
        tick();
        repeat (7) begin
            chv[2]++;
            tick();
        end
        ruc();
        repeat (6) tick();
        chk("arm_delta", mon_d[2], 32'd7);

        rnd_inc = 1'b1;
        for (int i = 0; i < 4; i++) chv[i] = $urandom();
        for (int k = 0; k < 1500; k++) begin
            out_ready = $urandom_range(0, 99) < (((k / 200) % 2 == 1) ? 30 : 85);
            ovf_clr = $urandom_range(0, 49) == 0;
            tick();
        end
        out_ready = 1'b1;
        ovf_clr = 1'b0;
        rnd_inc = 1'b0;
        repeat (3 * G) tick();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
